// File: rtl/riscv_defines.sv
// Shared types for the dual-issue allocator: per-instruction mini-decode
// payload, default queue depth and a register-compare helper.
package riscv_defines;

  localparam int unsigned ISSUE2_QDEPTH_DEF = 4;
  localparam int unsigned REG_AW            = 6;
  localparam int unsigned INSTR_W           = 32;

  typedef struct packed {
    logic              ra_used;
    logic              rb_used;
    logic              rc_used;
    logic [REG_AW-1:0] ra_addr;
    logic [REG_AW-1:0] rb_addr;
    logic [REG_AW-1:0] rc_addr;
    logic [REG_AW-1:0] waddr;
    logic              mem_we;
    logic              alu_we;
    logic              addr_ra_is_also_dst;
    logic              pi_legal;
    logic              i2_legal;
  } i2_dec_t;

  // Register 0 is hardwired, so it never participates in a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/issue2_pair_hazard.sv
// Combinational dependency check between the head instruction and the one
// behind it. Flags when any used source or destination of next_i overlaps a
// destination of head_i.
//   head_i   : decode of the older instruction
//   next_i   : decode of the younger instruction
//   hazard_o : pair must not dual-issue
module issue2_pair_hazard
  import riscv_defines::*;
(
  input  i2_dec_t head_i,
  input  i2_dec_t next_i,
  output logic    hazard_o
);

  // True when addr hits one of head's destinations.
  function automatic logic hits_head_dst(input i2_dec_t h,
                                         input logic [REG_AW-1:0] addr);
    return ((h.alu_we | h.mem_we) & reg_match(addr, h.waddr)) |
           (h.addr_ra_is_also_dst & reg_match(addr, h.ra_addr));
  endfunction

  always_comb begin
    hazard_o = 1'b0;
    if (next_i.ra_used && hits_head_dst(head_i, next_i.ra_addr)) hazard_o = 1'b1;
    if (next_i.rb_used && hits_head_dst(head_i, next_i.rb_addr)) hazard_o = 1'b1;
    if (next_i.rc_used && hits_head_dst(head_i, next_i.rc_addr)) hazard_o = 1'b1;
    if ((next_i.alu_we | next_i.mem_we) && hits_head_dst(head_i, next_i.waddr))
      hazard_o = 1'b1;
    if (next_i.addr_ra_is_also_dst && hits_head_dst(head_i, next_i.ra_addr))
      hazard_o = 1'b1;
  end

endmodule

// File: rtl/issue2_alloc_scheduler.sv
// In-order instruction queue feeding a primary pipe plus an optional paired
// second-issue slot. Optional 64-entry load scoreboard is built when
// ISSUE2_SCOREBOARD_EN is defined.
//   clk, rst_n              : clock, async active-low reset
//   flush_i                 : drop all queued entries (effective next cycle)
//   in_valid_i/in_ready_o   : enqueue handshake, in_instr_i + in_dec_i payload
//   pi_valid_o/pi_ready_i   : primary issue handshake, pi_instr_o word
//   i2_valid_o/i2_instr_o   : second issue, rides on the primary handshake
//   wb_valid_i/wb_addr_i    : load writeback, releases a scoreboard bit
module issue2_alloc_scheduler
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = ISSUE2_QDEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  i2_dec_t            in_dec_i,
  output logic               pi_valid_o,
  input  logic               pi_ready_i,
  output logic [INSTR_W-1:0] pi_instr_o,
  output logic               i2_valid_o,
  output logic [INSTR_W-1:0] i2_instr_o,
  input  logic               wb_valid_i,
  input  logic [REG_AW-1:0]  wb_addr_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  i2_dec_t            dec_mem   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nx_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          push, hazard, head_blk, next_blk;
  logic [1:0]    pop_n;
  i2_dec_t       head_dec, next_dec;

  assign nx_ptr     = rd_ptr_q + PW'(1);
  assign head_dec   = dec_mem[rd_ptr_q];
  assign next_dec   = dec_mem[nx_ptr];
  assign pi_instr_o = instr_mem[rd_ptr_q];
  assign i2_instr_o = instr_mem[nx_ptr];

  assign in_ready_o = (count_q < CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o & ~flush_i;

  issue2_pair_hazard u_pair_hazard (
    .head_i   (head_dec),
    .next_i   (next_dec),
    .hazard_o (hazard)
  );

`ifdef ISSUE2_SCOREBOARD_EN
  logic [63:0] sb_q, sb_d;

  // Any used source or destination waiting on an outstanding load.
  function automatic logic is_blocked(input i2_dec_t d, input logic [63:0] sb);
    return (d.ra_used & sb[d.ra_addr]) |
           (d.rb_used & sb[d.rb_addr]) |
           (d.rc_used & sb[d.rc_addr]) |
           ((d.alu_we | d.mem_we) & sb[d.waddr]) |
           (d.addr_ra_is_also_dst & sb[d.ra_addr]);
  endfunction

  assign head_blk = is_blocked(head_dec, sb_q);
  assign next_blk = is_blocked(next_dec, sb_q);

  // Writeback clears first so a same-cycle issue to that register re-sets it.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid_i) sb_d[wb_addr_i] = 1'b0;
    if (pop_n != 2'd0 && head_dec.mem_we && head_dec.waddr != '0)
      sb_d[head_dec.waddr] = 1'b1;
    if (pop_n == 2'd2 && next_dec.mem_we && next_dec.waddr != '0)
      sb_d[next_dec.waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_addr_i};
  assign head_blk  = 1'b0;
  assign next_blk  = 1'b0;
`endif

  assign pi_valid_o = (count_q != '0) & ~head_blk;
  assign i2_valid_o = pi_valid_o & (count_q >= CW'(2)) & head_dec.pi_legal &
                      next_dec.i2_legal & ~next_blk & ~hazard;

  // Pop count; second slot only moves together with the primary.
  always_comb begin
    pop_n = 2'd0;
    if (pi_valid_o && pi_ready_i) pop_n = i2_valid_o ? 2'd2 : 2'd1;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop_n);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr_i;
      dec_mem[wr_ptr_q]   <= in_dec_i;
    end
  end

endmodule

// File: tb/tb_issue2_alloc_scheduler.sv
// Directed bench for issue2_alloc_scheduler: hazard pairing, full queue,
// flush, async reset, and load-scoreboard behaviour (either build).
module tb_issue2_alloc_scheduler;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  i2_dec_t     in_dec_i;
  logic        pi_valid_o;
  logic        pi_ready_i;
  logic [31:0] pi_instr_o;
  logic        i2_valid_o;
  logic [31:0] i2_instr_o;
  logic        wb_valid_i;
  logic [5:0]  wb_addr_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue2_alloc_scheduler #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_instr_i (in_instr_i),
    .in_dec_i   (in_dec_i),
    .pi_valid_o (pi_valid_o),
    .pi_ready_i (pi_ready_i),
    .pi_instr_o (pi_instr_o),
    .i2_valid_o (i2_valid_o),
    .i2_instr_o (i2_instr_o),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic i2_dec_t mk(input logic ru, input logic [5:0] ra,
                                 input logic rbu, input logic [5:0] rb,
                                 input logic [5:0] wd, input logic alu,
                                 input logic mem, input logic i2l);
    i2_dec_t d;
    d = '0;
    d.ra_used = ru;  d.ra_addr = ra;
    d.rb_used = rbu; d.rb_addr = rb;
    d.waddr = wd; d.alu_we = alu; d.mem_we = mem;
    d.pi_legal = 1'b1; d.i2_legal = i2l;
    return d;
  endfunction

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input i2_dec_t d);
    in_valid_i = 1'b1; in_instr_i = w; in_dec_i = d;
    cyc();
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    pi_ready_i = 1'b1;
    repeat (n) cyc();
    pi_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_instr_i = '0;
    in_dec_i = '0; pi_ready_i = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0;
    repeat (2) cyc();
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_pi_valid", 32'(pi_valid_o), 32'd0);
    check("rst_i2_valid", 32'(i2_valid_o), 32'd0);
    rst_n = 1'b1;
    cyc();

    // RAW on x5: addi x5,x1 then add x6,x5,x1
    push(32'h00008293, mk(1, 6'd1, 0, 6'd0, 6'd5, 1, 0, 1));
    push(32'h00128333, mk(1, 6'd5, 1, 6'd1, 6'd6, 1, 0, 1));
    check("raw_pi_valid", 32'(pi_valid_o), 32'd1);
    check("raw_i2_valid", 32'(i2_valid_o), 32'd0);
    check("raw_pi_instr", pi_instr_o, 32'h00008293);
    pi_ready_i = 1'b1;
    cyc();
    check("raw_pop1_valid", 32'(pi_valid_o), 32'd1);
    check("raw_pop1_instr", pi_instr_o, 32'h00128333);
    check("raw_pop1_i2", 32'(i2_valid_o), 32'd0);
    cyc();
    pi_ready_i = 1'b0;
    check("raw_empty", 32'(pi_valid_o), 32'd0);

    // Independent pair dual-issues and pops 2
    push(32'h002082b3, mk(1, 6'd1, 1, 6'd2, 6'd5, 1, 0, 1));
    push(32'h00418333, mk(1, 6'd3, 1, 6'd4, 6'd6, 1, 0, 1));
    check("pair_pi_valid", 32'(pi_valid_o), 32'd1);
    check("pair_i2_valid", 32'(i2_valid_o), 32'd1);
    check("pair_i2_instr", i2_instr_o, 32'h00418333);
    drain(1);
    check("pair_popped_pi", 32'(pi_valid_o), 32'd0);
    check("pair_popped_i2", 32'(i2_valid_o), 32'd0);

    // WAW on x5 blocks pairing
    push(32'h11111111, mk(1, 6'd1, 0, 6'd0, 6'd5, 1, 0, 1));
    push(32'h22222222, mk(1, 6'd3, 0, 6'd0, 6'd5, 1, 0, 1));
    check("waw_i2_valid", 32'(i2_valid_o), 32'd0);
    drain(2);

    // x0 as head dest and next sources never conflicts
    push(32'h33333333, mk(1, 6'd1, 0, 6'd0, 6'd0, 1, 0, 1));
    push(32'h44444444, mk(1, 6'd0, 1, 6'd0, 6'd7, 1, 0, 1));
    check("x0_i2_valid", 32'(i2_valid_o), 32'd1);
    drain(1);
    check("x0_popped", 32'(pi_valid_o), 32'd0);

    // Younger not i2-legal
    push(32'h55555555, mk(1, 6'd1, 0, 6'd0, 6'd9, 1, 0, 1));
    push(32'h66666666, mk(1, 6'd2, 0, 6'd0, 6'd10, 1, 0, 0));
    check("illegal_i2_valid", 32'(i2_valid_o), 32'd0);
    drain(2);

    // Fill to DEPTH, fifth push dropped, order preserved
    for (int i = 0; i < 4; i++)
      push(32'hA000_0000 + 32'(i), mk(1, 6'd1, 0, 6'd0, 6'(10 + i), 1, 0, 0));
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    push(32'hDEADBEEF, mk(1, 6'd1, 0, 6'd0, 6'd20, 1, 0, 0));
    check("full_after_5th", 32'(in_ready_o), 32'd0);
    pi_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_order_valid", 32'(pi_valid_o), 32'd1);
      check("full_order_instr", pi_instr_o, 32'hA000_0000 + 32'(i));
      cyc();
    end
    pi_ready_i = 1'b0;
    check("full_drained", 32'(pi_valid_o), 32'd0);

    // Flush with count=3 and a simultaneous push
    for (int i = 0; i < 3; i++)
      push(32'hB000_0000 + 32'(i), mk(1, 6'd1, 0, 6'd0, 6'd11, 1, 0, 1));
    flush_i = 1'b1; in_valid_i = 1'b1; in_instr_i = 32'hCAFE0000;
    check("flush_cycle_pi_valid", 32'(pi_valid_o), 32'd1);
    cyc();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_pi_valid", 32'(pi_valid_o), 32'd0);
    check("flush_in_ready", 32'(in_ready_o), 32'd1);
    cyc();
    check("flush_push_dropped", 32'(pi_valid_o), 32'd0);

    // Async reset mid-stream with count=2
    push(32'hC0000001, mk(1, 6'd1, 0, 6'd0, 6'd12, 1, 0, 1));
    push(32'hC0000002, mk(1, 6'd2, 0, 6'd0, 6'd13, 1, 0, 1));
    check("pre_rst_i2_valid", 32'(i2_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pi_valid", 32'(pi_valid_o), 32'd0);
    check("midrst_i2_valid", 32'(i2_valid_o), 32'd0);
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("postrst_empty", 32'(pi_valid_o), 32'd0);

    // Load then dependent add
    push(32'h0000A383, mk(1, 6'd1, 0, 6'd0, 6'd7, 0, 1, 1));
    drain(1);
    push(32'h00138433, mk(1, 6'd7, 1, 6'd1, 6'd8, 1, 0, 1));
`ifdef ISSUE2_SCOREBOARD_EN
    check("sb_blocked0", 32'(pi_valid_o), 32'd0);
    wb_valid_i = 1'b1; wb_addr_i = 6'd9;
    cyc();
    wb_valid_i = 1'b0;
    check("sb_other_wb", 32'(pi_valid_o), 32'd0);
    wb_valid_i = 1'b1; wb_addr_i = 6'd7;
    check("sb_wb_cycle", 32'(pi_valid_o), 32'd0);
    cyc();
    wb_valid_i = 1'b0;
    check("sb_released", 32'(pi_valid_o), 32'd1);
    check("sb_released_instr", pi_instr_o, 32'h00138433);
`else
    check("nosb_not_blocked", 32'(pi_valid_o), 32'd1);
    check("nosb_instr", pi_instr_o, 32'h00138433);
`endif
    drain(1);
    check("final_empty", 32'(pi_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue2_alloc_scheduler.md
ISSUE2_ALLOC_SCHEDULER -- requirements
Module: issue2_alloc_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 4, instruction queue entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  block clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush_i  input  1  discard all queued instructions.
REQ-005 SHALL have port in_valid_i  input  1  fetched instruction valid.
REQ-006 SHALL have port in_ready_o  output  1  queue can accept one instruction.
REQ-007 SHALL have port in_instr_i  input  32  raw instruction word.
REQ-008 SHALL have port in_dec_i  input  i2_dec_t  mini-decode fields: ra/rb/rc used, ra/rb/rc addr[5:0], waddr[5:0], mem_we, alu_we, addr_ra_is_also_dst, pi_legal, i2_legal.
REQ-009 SHALL have port pi_valid_o  output  1  primary-issue instruction valid.
REQ-010 SHALL have port pi_ready_i  input  1  primary pipe accepts.
REQ-011 SHALL have port pi_instr_o  output  32  primary-issue instruction word.
REQ-012 SHALL have port i2_valid_o  output  1  second-issue instruction valid, paired with primary.
REQ-013 SHALL have port i2_instr_o  output  32  second-issue instruction word.
REQ-014 SHALL have port wb_valid_i  input  1  load writeback occurred.
REQ-015 SHALL have port wb_addr_i  input  6  load writeback register address.

Function
REQ-016 SHALL hold instructions in an in-order circular FIFO; in_ready_o = (count < DEPTH), from current count only, no same-cycle pop bypass.
REQ-017 SHALL push when in_valid_i & in_ready_o & !flush_i.
REQ-018 SHALL drive pi_valid_o = (count>=1) & !blocked(head); pi_instr_o = head word, combinational from FIFO.
REQ-019 SHALL drive i2_valid_o = pi_valid_o & (count>=2) & head.pi_legal & next.i2_legal & !blocked(next) & !hazard(head,next).
REQ-020 SHALL define dest set of X: waddr if alu_we|mem_we, plus ra addr if addr_ra_is_also_dst.
REQ-021 SHALL flag hazard when a used source (ra/rb/rc) or dest of next equals any dest of head; address 6'd0 never matches.
REQ-022 SHALL pop 1 entry when pi_valid_o & pi_ready_i & !i2_valid_o, 2 when both valid and pi_ready_i; i2 never issues without primary.
REQ-023 SHALL, on flush_i, set count, read and write pointers to 0 next cycle; flush wins over simultaneous push and pop.
REQ-024 SHALL leave outputs unaffected by flush_i in its assertion cycle (registered effect).

Reset
REQ-025 SHALL on rst_n low clear pointers, count, scoreboard; in_ready_o=1, pi_valid_o=0, i2_valid_o=0, instruction outputs don't-care; reset mid-operation drops queued entries.

Configuration
REQ-026 SHALL implement a 64-bit load scoreboard only when ISSUE2_SCOREBOARD_EN is defined.
REQ-027 With macro: bit waddr set when issued instruction has mem_we & waddr!=0; cleared on wb_valid_i at wb_addr_i; same-cycle set and clear of same bit -> set wins; blocked(X) = any used source or dest of X has set bit.
REQ-028 Without macro: no scoreboard storage, blocked(X)=0, wb_* ignored.

Structure
REQ-029 SHALL place i2_dec_t struct and ISSUE2_QDEPTH_DEF constant in riscv_defines.
REQ-030 SHALL implement pair-hazard comparison in sub-module issue2_pair_hazard (combinational).

Verification
REQ-031 Push addi x5 then add x6,x5,x1, pi_ready=1 -> pi_valid=1, i2_valid=0 (RAW on x5), pop 1.
REQ-032 Push add x5,x1,x2 then add x6,x3,x4, both legal -> pi_valid=1, i2_valid=1, count 2->0 next cycle.
REQ-033 Push DEPTH=4 entries with pi_ready=0 -> in_ready_o=0; fifth push ignored, count stays 4.
REQ-034 Flush with count=3 and simultaneous push -> next cycle count=0, pi_valid=0.
REQ-035 Macro on: issue lw x7, then add x8,x7,x1 -> pi_valid=0 until wb_valid_i with wb_addr_i=7; issues cycle after.
REQ-036 Assert rst_n low mid-stream with count=2 -> outputs invalid immediately, in_ready_o=1.
